asm_mult_ctrl: RTL and testbench

Sequential shift-add unsigned binary multiplier: an ASM-style control unit sequencing a register datapath.
- Datapath: registers B, A, Q, carry E, down-counter P.
- Controller: 2-bit binary state register plus a one-hot decoded state output.
- Sits beside other textbook control-unit blocks as a reusable multiply engine with a start/done handshake.

---
 rtl/asm_mult_ctrl_if.sv | 29 ++
 rtl/asm_mult_ctrl.sv | 111 +++++++++++
 tb/tb_asm_mult_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/asm_mult_ctrl_if.sv
// Start/done handshake and operand/result bus for the shift-add multiply engine.
interface asm_mult_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/asm_mult_ctrl.sv
// ASM-controlled shift-add unsigned multiplier (registers B, A, Q, carry E, counter P).
// Optional ASM_MULT_SKIP_ZERO_EN: a zero operand jumps straight from IDLE to DONE.
module asm_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_b,
    asm_mult_ctrl_if.slave     bus,
    output logic [1:0]         state,
    output logic [3:0]         state_dec
);
    localparam int PW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ADD   = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               e_q, e_d;
    logic [PW-1:0]      p_q, p_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH:0]     sum;

    assign sum = {1'b0, a_q} + {1'b0, b_q};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            q_q       <= '0;
            e_q       <= 1'b0;
            p_q       <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            q_q       <= q_d;
            e_q       <= e_d;
            p_q       <= p_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        q_d       = q_q;
        e_d       = e_q;
        p_d       = p_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    b_d     = bus.multiplicand;
                    q_d     = bus.multiplier;
                    a_d     = '0;
                    e_d     = 1'b0;
                    p_d     = PW'(WIDTH);
                    state_d = ADD;
`ifdef ASM_MULT_SKIP_ZERO_EN
                    if ((bus.multiplicand == '0) || (bus.multiplier == '0)) begin
                        q_d     = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            ADD: begin
                p_d = p_q - PW'(1);
                if (q_q[0]) begin
                    {e_d, a_d} = sum;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d = {e_q, a_q[WIDTH-1:1]};
                q_d = {a_q[0], q_q[WIDTH-1:1]};
                e_d = 1'b0;
                // P already holds the post-decrement count from the preceding ADD
                state_d = (p_q == '0) ? DONE : ADD;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Capture the finished {A,Q} only on the edge entering DONE so product never shows partial sums
        if ((state_d == DONE) && (state_q != DONE)) begin
            product_d = {a_d, q_d};
        end
    end

    assign state       = state_q;
    assign state_dec   = 4'b0001 << state_q;
    assign bus.busy    = (state_q == ADD) || (state_q == SHIFT);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_asm_mult_ctrl.sv
// Scoreboard bench for asm_mult_ctrl: products queued at start, popped and compared on done.
module tb_asm_mult_ctrl;
    localparam int WIDTH      = 4;
    localparam int PW         = 2 * WIDTH;
    localparam int CLK_PERIOD = 10;

    logic       clk   = 1'b0;
    logic       rst_b = 1'b0;
    logic [1:0] state;
    logic [3:0] state_dec;

    int            checks   = 0;
    int            failures = 0;
    logic [PW-1:0] sb_q[$];
    logic [PW-1:0] last_product;
    time           done_time;

    asm_mult_ctrl_if #(.WIDTH(WIDTH)) bus ();

    asm_mult_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .bus       (bus.slave),
        .state     (state),
        .state_dec (state_dec)
    );

    always #(CLK_PERIOD / 2) clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full request: push expected product, walk the state sequence, pop on done.
    task automatic run_multiply(input logic [WIDTH-1:0] mc, input logic [WIDTH-1:0] mp,
                                input bit keep_start, input int poke_at);
        int            nsteps;
        bit            skip;
        bit            got_done;
        logic [PW-1:0] exp_p;
        logic [1:0]    exp_s;
        skip = 1'b0;
`ifdef ASM_MULT_SKIP_ZERO_EN
        skip = (mc == '0) || (mp == '0);
`endif
        nsteps   = skip ? 0 : 2 * WIDTH;
        got_done = 1'b0;
        checks++;
        if (state !== 2'b00) begin
            failures++;
            $display("[TB] FAIL entry_idle: state=%b required 00", state);
        end
        bus.multiplicand = mc;
        bus.multiplier   = mp;
        bus.start        = 1'b1;
        sb_q.push_back(PW'(mc) * PW'(mp));
        for (int i = 0; i <= nsteps; i++) begin
            step();
            if (i == 0 && !keep_start) begin
                bus.start        = 1'b0;
                bus.multiplicand = WIDTH'($urandom);
                bus.multiplier   = WIDTH'($urandom);
            end
            if (i == poke_at) begin
                bus.start        = 1'b1;
                bus.multiplicand = 2;
                bus.multiplier   = 3;
            end else if (poke_at >= 0 && i == poke_at + 1) begin
                bus.start = 1'b0;
            end
            exp_s = (i == nsteps) ? 2'b11 : ((i % 2 == 0) ? 2'b01 : 2'b10);
            checks++;
            if (state !== exp_s) begin
                failures++;
                $display("[TB] FAIL state_seq: cycle %0d state=%b required %b", i, state, exp_s);
            end
            checks++;
            if (state_dec !== (4'b0001 << exp_s)) begin
                failures++;
                $display("[TB] FAIL state_dec: cycle %0d state_dec=%b required %b", i, state_dec, 4'b0001 << exp_s);
            end
            checks++;
            if (bus.busy !== (i != nsteps)) begin
                failures++;
                $display("[TB] FAIL busy: cycle %0d busy=%b required %b", i, bus.busy, i != nsteps);
            end
            checks++;
            if (bus.done !== (i == nsteps)) begin
                failures++;
                $display("[TB] FAIL done: cycle %0d done=%b required %b", i, bus.done, i == nsteps);
            end
            if (bus.done === 1'b1 && !got_done) begin
                got_done  = 1'b1;
                done_time = $time;
                exp_p     = sb_q.pop_front();
                checks++;
                if (bus.product !== exp_p) begin
                    failures++;
                    $display("[TB] FAIL product: %0d x %0d product=%0d required %0d", mc, mp, bus.product, exp_p);
                end
                checks++;
                if (i != nsteps) begin
                    failures++;
                    $display("[TB] FAIL latency: done after %0d cycles required %0d", i, nsteps);
                end
                last_product = exp_p;
            end else if (i != nsteps) begin
                checks++;
                if (bus.product !== last_product) begin
                    failures++;
                    $display("[TB] FAIL product_hold: cycle %0d product=%0d required %0d", i, bus.product, last_product);
                end
            end
        end
        if (!got_done) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout: no done within %0d cycles, required 1 pulse", nsteps);
            sb_q.delete();
        end
        step();
        checks++;
        if (state !== 2'b00 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL back_to_idle: state=%b done=%b busy=%b required 00/0/0", state, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (state !== 2'b00) begin failures++; $display("[TB] FAIL reset_state: %b required 00", state); end
        checks++;
        if (state_dec !== 4'b0001) begin failures++; $display("[TB] FAIL reset_dec: %b required 0001", state_dec); end
        checks++;
        if (bus.product !== '0) begin failures++; $display("[TB] FAIL reset_product: %0d required 0", bus.product); end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: busy=%b done=%b required 0/0", bus.busy, bus.done);
        end
        @(negedge clk);
        rst_b = 1'b1;
        step();
        last_product = '0;
    endtask

    task automatic test_basic();
        run_multiply(4'd13, 4'd11, 1'b0, -1);
        run_multiply(4'd15, 4'd15, 1'b0, -1);
        run_multiply(4'd1, 4'd1, 1'b0, -1);
        for (int n = 0; n < 4; n++) begin
            run_multiply(WIDTH'($urandom_range(1, 15)), WIDTH'($urandom_range(1, 15)), 1'b0, -1);
        end
    endtask

    task automatic test_start_while_busy();
        run_multiply(4'd13, 4'd11, 1'b0, 3);
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (bus.done !== 1'b0 || state !== 2'b00) begin
                failures++;
                $display("[TB] FAIL ignored_start: done=%b state=%b required 0/00", bus.done, state);
            end
        end
    endtask

    task automatic test_back_to_back();
        time t_first;
        run_multiply(4'd5, 4'd9, 1'b1, -1);
        t_first = done_time;
        run_multiply(4'd5, 4'd9, 1'b1, -1);
        checks++;
        if ((done_time - t_first) !== time'((2 * WIDTH + 2) * CLK_PERIOD)) begin
            failures++;
            $display("[TB] FAIL done_period: %0t required %0d", done_time - t_first, (2 * WIDTH + 2) * CLK_PERIOD);
        end
        run_multiply(4'd5, 4'd9, 1'b0, -1);
    endtask

    task automatic test_reset_mid_run();
        bus.multiplicand = 4'd13;
        bus.multiplier   = 4'd11;
        bus.start        = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if (state !== 2'b00 || state_dec !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL midrun_reset_state: state=%b dec=%b required 00/0001", state, state_dec);
        end
        checks++;
        if (bus.product !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrun_reset_outputs: product=%0d busy=%b done=%b required 0/0/0",
                     bus.product, bus.busy, bus.done);
        end
        @(negedge clk);
        rst_b = 1'b1;
        step();
        last_product = '0;
        run_multiply(4'd6, 4'd7, 1'b0, -1);
    endtask

    task automatic test_zero_operand();
        run_multiply(4'd0, 4'd9, 1'b0, -1);
        run_multiply(4'd9, 4'd0, 1'b0, -1);
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        last_product     = '0;
        done_time        = 0;
        test_reset();
        test_basic();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_zero_operand();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
